// File: rtl/xls_sum_tree_pkg.sv
// Shared types and elaboration-time helpers for the pipelined N-operand sum tree.
// The tree shape (operand count per level, bus offsets) is derived here so every file agrees.
package xls_sum_tree_pkg;

    typedef enum logic {
        SUM_WRAP = 1'b0,
        SUM_SAT  = 1'b1
    } sum_mode_e;

    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

    // Operands remaining after lvl levels of pairwise reduction.
    function automatic int level_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) begin
            c = ceil_half(c);
        end
        return c;
    endfunction

    // Bit offset of level lvl inside the flattened tree bus (level 0 = registered operands).
    function automatic int tree_offset(input int n, input int ext, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off += level_count(n, i) * ext;
        end
        return off;
    endfunction

endpackage

// File: rtl/xls_sum_tree_level.sv
// One reduction level of the sum tree: adds adjacent operand pairs, an odd last operand
// passes through, and the result is captured in this level's valid/data register.
module xls_sum_tree_level
    import xls_sum_tree_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int EXT = 33,
    localparam int N_OUT = ceil_half(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  sum_mode_e            i_mode,
    input  logic [N_IN*EXT-1:0]  i_data,
    input  logic                 i_load,
    output logic                 o_valid,
    output sum_mode_e            o_mode,
    output logic [N_OUT*EXT-1:0] o_data
);

    logic [N_OUT*EXT-1:0] w_sum;
    logic                 r_valid;
    sum_mode_e            r_mode;
    logic [N_OUT*EXT-1:0] r_data;

    // EXT already carries the tree's growth bits, so no addition here can carry out.
    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            assign w_sum[j*EXT +: EXT] = i_data[(2*j)*EXT +: EXT] + i_data[(2*j+1)*EXT +: EXT];
        end else begin : g_pass
            assign w_sum[j*EXT +: EXT] = i_data[(2*j)*EXT +: EXT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_mode  <= SUM_WRAP;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_mode <= i_mode;
                r_data <= w_sum;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_mode  = r_mode;
    assign o_data  = r_data;

endmodule

// File: rtl/xls_sum_tree_pipe.sv
// Pipelined N_OPS-operand unsigned adder tree with per-operand enable, wrap/saturate mode,
// overflow flag and valid/ready flow control; latency LVL+2, one result per cycle.
module xls_sum_tree_pipe
    import xls_sum_tree_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_OPS = 6,
    localparam int LVL = $clog2(N_OPS),
    localparam int EXT = WIDTH + LVL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_OPS*WIDTH-1:0] in_ops,
    input  logic [N_OPS-1:0]       in_en,
    input  logic                   in_sat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_ovf
);

    localparam int TREE_W = tree_offset(N_OPS, EXT, LVL + 1);
    localparam int FIN    = tree_offset(N_OPS, EXT, LVL);

    logic [TREE_W-1:0]      w_tree;
    logic [N_OPS*EXT-1:0]   w_masked;
    logic [LVL+1:0]         w_load;
    logic [LVL:0]           w_valid;
    sum_mode_e              w_mode [0:LVL];
    logic [EXT-1:0]         w_fin_sum;
    logic                   w_fin_ovf;

    logic                   r_s0_valid;
    sum_mode_e              r_s0_mode;
    logic [N_OPS*EXT-1:0]   r_s0_data;
    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_out_sum;
    logic                   r_out_ovf;

    for (genvar i = 0; i < N_OPS; i++) begin : g_mask
        assign w_masked[i*EXT +: EXT] = in_en[i] ? {{LVL{1'b0}}, in_ops[i*WIDTH +: WIDTH]} : '0;
    end

    // Handshake: a transfer happens on a cycle where valid && ready are both high. Every
    // register stage (S0, tree levels, output) loads when it is empty or the stage after it
    // loads, so a bubble anywhere lets upstream move; out_ready reaches in_ready only through
    // this chain, and a stalled stage keeps its contents unchanged.
    always_comb begin
        w_load = '0;
        w_load[LVL+1] = !r_out_valid || out_ready;
        for (int k = LVL; k >= 1; k--) begin
            w_load[k] = !w_valid[k] || w_load[k+1];
        end
        w_load[0] = !r_s0_valid || w_load[1];
    end

    assign in_ready = w_load[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0_valid <= 1'b0;
            r_s0_mode  <= SUM_WRAP;
            r_s0_data  <= '0;
        end else if (w_load[0]) begin
            r_s0_valid <= in_valid;
            if (in_valid) begin
                r_s0_mode <= sum_mode_e'(in_sat);
                r_s0_data <= w_masked;
            end
        end
    end

    assign w_valid[0]                = r_s0_valid;
    assign w_mode[0]                 = r_s0_mode;
    assign w_tree[0 +: N_OPS*EXT]    = r_s0_data;

    for (genvar k = 1; k <= LVL; k++) begin : g_lvl
        localparam int NI    = level_count(N_OPS, k - 1);
        localparam int NO    = level_count(N_OPS, k);
        localparam int OFF_I = tree_offset(N_OPS, EXT, k - 1);
        localparam int OFF_O = tree_offset(N_OPS, EXT, k);

        xls_sum_tree_level #(
            .N_IN (NI),
            .EXT  (EXT)
        ) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k-1]),
            .i_mode  (w_mode[k-1]),
            .i_data  (w_tree[OFF_I +: NI*EXT]),
            .i_load  (w_load[k]),
            .o_valid (w_valid[k]),
            .o_mode  (w_mode[k]),
            .o_data  (w_tree[OFF_O +: NO*EXT])
        );
    end

    // Any set bit above WIDTH means the true sum no longer fits the result width.
    assign w_fin_sum = w_tree[FIN +: EXT];
    assign w_fin_ovf = |w_fin_sum[EXT-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_load[LVL+1]) begin
            r_out_valid <= w_valid[LVL];
            if (w_valid[LVL]) begin
                r_out_ovf <= w_fin_ovf;
                r_out_sum <= (w_mode[LVL] == SUM_SAT && w_fin_ovf) ? '1 : w_fin_sum[WIDTH-1:0];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_xls_sum_tree_pipe.sv
// Directed and randomized bench for xls_sum_tree_pipe: a 32-bit/6-operand instance plus
// 8-bit instances with 2, 3, 5 and 64 operands, all checked against an arithmetic model.
module tb_xls_sum_tree_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Main instance: WIDTH=32, N_OPS=6.
    logic         m_in_valid = 1'b0;
    logic         m_in_ready;
    logic [191:0] m_in_ops = '0;
    logic [5:0]   m_in_en = '0;
    logic         m_in_sat = 1'b0;
    logic         m_out_valid;
    logic         m_out_ready = 1'b1;
    logic [31:0]  m_out_sum;
    logic         m_out_ovf;

    xls_sum_tree_pipe #(.WIDTH(32), .N_OPS(6)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready), .in_ops(m_in_ops),
        .in_en(m_in_en), .in_sat(m_in_sat),
        .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_sum(m_out_sum), .out_ovf(m_out_ovf)
    );

    // Sweep instances: WIDTH=8 with 2, 3, 5, 64 operands sharing one stimulus bus.
    logic            sw_valid = 1'b0;
    logic [511:0]    sw_ops = '0;
    logic [63:0]     sw_en = '0;
    logic            sw_sat = 1'b0;
    logic            sw_out_ready = 1'b1;
    logic [3:0]      sw_in_ready;
    logic [3:0]      sw_out_valid;
    logic [3:0]      sw_out_ovf;
    logic [3:0][7:0] sw_out_sum;
    int              sw_n [4] = '{2, 3, 5, 64};

    xls_sum_tree_pipe #(.WIDTH(8), .N_OPS(2)) u_sw2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[0]), .in_ops(sw_ops[15:0]),
        .in_en(sw_en[1:0]), .in_sat(sw_sat),
        .out_valid(sw_out_valid[0]), .out_ready(sw_out_ready),
        .out_sum(sw_out_sum[0]), .out_ovf(sw_out_ovf[0])
    );
    xls_sum_tree_pipe #(.WIDTH(8), .N_OPS(3)) u_sw3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[1]), .in_ops(sw_ops[23:0]),
        .in_en(sw_en[2:0]), .in_sat(sw_sat),
        .out_valid(sw_out_valid[1]), .out_ready(sw_out_ready),
        .out_sum(sw_out_sum[1]), .out_ovf(sw_out_ovf[1])
    );
    xls_sum_tree_pipe #(.WIDTH(8), .N_OPS(5)) u_sw5 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[2]), .in_ops(sw_ops[39:0]),
        .in_en(sw_en[4:0]), .in_sat(sw_sat),
        .out_valid(sw_out_valid[2]), .out_ready(sw_out_ready),
        .out_sum(sw_out_sum[2]), .out_ovf(sw_out_ovf[2])
    );
    xls_sum_tree_pipe #(.WIDTH(8), .N_OPS(64)) u_sw64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(sw_valid), .in_ready(sw_in_ready[3]), .in_ops(sw_ops),
        .in_en(sw_en), .in_sat(sw_sat),
        .out_valid(sw_out_valid[3]), .out_ready(sw_out_ready),
        .out_sum(sw_out_sum[3]), .out_ovf(sw_out_ovf[3])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain sum of enabled operands, then wrap or clamp to w bits.
    function automatic logic [32:0] ref_sum(input int w, input int n, input logic [511:0] ops,
                                            input logic [63:0] en, input logic sat);
        longint unsigned total, mask, op;
        logic ovf;
        logic [63:0] res;
        total = 0;
        mask = (64'd1 << w) - 64'd1;
        for (int i = 0; i < n; i++) begin
            if (en[i]) begin
                op = 64'(ops >> (i * w)) & mask;
                total += op;
            end
        end
        ovf = (total > mask);
        res = (sat && ovf) ? mask : (total & mask);
        return {ovf, res[31:0]};
    endfunction

    function automatic int ref_lat(input int n);
        int l;
        l = 0;
        while ((1 << l) < n) l++;
        return l + 2;
    endfunction

    function automatic logic [191:0] pack6(input logic [31:0] a, b, c, d, e, f);
        return {f, e, d, c, b, a};
    endfunction

    function automatic logic [191:0] rand_ops6();
        logic [191:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One isolated transaction on the main instance with out_ready held high.
    task automatic main_one(input string tag, input logic [191:0] ops, input logic [5:0] en,
                            input logic sat, input logic [31:0] exp_sum, input logic exp_ovf);
        int lat;
        m_in_ops = ops;
        m_in_en = en;
        m_in_sat = sat;
        m_in_valid = 1'b1;
        m_out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(m_in_ready), 64'd1);
        @(posedge clk);
        #1;
        m_in_valid = 1'b0;
        lat = 1;
        while (!m_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd5);
        chk({tag, "_sum"}, 64'(m_out_sum), 64'(exp_sum));
        chk({tag, "_ovf"}, 64'(m_out_ovf), 64'(exp_ovf));
        tick();
    endtask

    initial begin
        logic [32:0]  exp_q [$];
        logic [32:0]  e;
        logic [191:0] ops;
        logic [5:0]   en;
        logic         sat;
        int           sent, got, cyc, drop_at, k;
        logic         held_valid, in_fire, out_fire;
        logic [31:0]  held_sum;
        logic         held_ovf;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_out_sum", 64'(m_out_sum), 64'd0);
        chk("rst_out_ovf", 64'(m_out_ovf), 64'd0);
        chk("rst_sw_out_valid", 64'(sw_out_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(m_in_ready), 64'd1);
        tick();

        // Directed main-instance cases.
        main_one("seq1to6", pack6(1, 2, 3, 4, 5, 6), 6'h3F, 1'b0, 32'd21, 1'b0);
        main_one("ones_wrap", {6{32'hFFFF_FFFF}}, 6'h3F, 1'b0, 32'hFFFF_FFFA, 1'b1);
        main_one("ones_sat", {6{32'hFFFF_FFFF}}, 6'h3F, 1'b1, 32'hFFFF_FFFF, 1'b1);
        main_one("en_one", pack6(10, 20, 30, 40, 50, 60), 6'b000010, 1'b0, 32'd20, 1'b0);
        main_one("en_zero", pack6(10, 20, 30, 40, 50, 60), 6'b000000, 1'b1, 32'd0, 1'b0);

        // Random isolated transactions.
        for (int t = 0; t < 8; t++) begin
            ops = rand_ops6();
            en = 6'($urandom_range(0, 63));
            sat = 1'($urandom_range(0, 1));
            e = ref_sum(32, 6, {320'd0, ops}, {58'd0, en}, sat);
            main_one($sformatf("rand%0d", t), ops, en, sat, e[31:0], e[32]);
        end

        // Back-to-back stream under backpressure: stalled 8 cycles, then toggling.
        sent = 0; got = 0; cyc = 0; drop_at = -1; held_valid = 1'b0;
        held_sum = '0; held_ovf = 1'b0;
        ops = rand_ops6();
        en = 6'($urandom_range(0, 63));
        sat = 1'($urandom_range(0, 1));
        while (got < 20 && cyc < 300) begin
            m_out_ready = (cyc < 8) ? 1'b0 : 1'(cyc % 2);
            m_in_valid = (sent < 20);
            m_in_ops = ops;
            m_in_en = en;
            m_in_sat = sat;
            #1;
            if (held_valid) begin
                chk("bp_hold_valid", 64'(m_out_valid), 64'd1);
                chk("bp_hold_sum", 64'(m_out_sum), 64'(held_sum));
                chk("bp_hold_ovf", 64'(m_out_ovf), 64'(held_ovf));
            end
            if (m_in_valid && !m_in_ready && drop_at < 0) drop_at = sent;
            in_fire = m_in_valid && m_in_ready;
            out_fire = m_out_valid && m_out_ready;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    chk("bp_unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("bp_sum%0d", got), 64'(m_out_sum), 64'(e[31:0]));
                    chk($sformatf("bp_ovf%0d", got), 64'(m_out_ovf), 64'(e[32]));
                end
                got++;
            end
            held_valid = m_out_valid && !m_out_ready;
            held_sum = m_out_sum;
            held_ovf = m_out_ovf;
            if (in_fire) begin
                exp_q.push_back(ref_sum(32, 6, {320'd0, ops}, {58'd0, en}, sat));
                sent++;
                ops = rand_ops6();
                en = 6'($urandom_range(0, 63));
                sat = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #0;
            cyc++;
        end
        #1;
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        chk("bp_ready_drop_after", 64'(drop_at), 64'd5);
        chk("bp_results", 64'(got), 64'd20);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
        chk("bp_drained", 64'(m_out_valid), 64'd0);

        // Asynchronous reset with three results in flight.
        exp_q.delete();
        m_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ops = pack6($urandom_range(1, 1000), $urandom_range(1, 1000), $urandom_range(1, 1000),
                        $urandom_range(1, 1000), $urandom_range(1, 1000), $urandom_range(1, 1000));
            m_in_ops = ops;
            m_in_en = 6'h3F;
            m_in_sat = 1'b0;
            m_in_valid = 1'b1;
            exp_q.push_back(ref_sum(32, 6, {320'd0, ops}, 64'h3F, 1'b0));
            tick();
        end
        m_in_valid = 1'b0;
        k = 0;
        while (!m_out_valid && k < 10) begin
            tick();
            k++;
        end
        e = exp_q.pop_front();
        chk("rst_mid_pre_valid", 64'(m_out_valid), 64'd1);
        chk("rst_mid_pre_sum", 64'(m_out_sum), 64'(e[31:0]));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(m_out_valid), 64'd0);
        chk("rst_mid_out_sum", 64'(m_out_sum), 64'd0);
        chk("rst_mid_out_ovf", 64'(m_out_ovf), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        m_out_ready = 1'b1;
        tick();
        main_one("post_rst", pack6(7, 0, 0, 0, 0, 0), 6'h3F, 1'b0, 32'd7, 1'b0);

        // WIDTH=8 sweep over 2, 3, 5, 64 operands.
        for (int t = 0; t < 12; t++) begin
            int          lat [4];
            int          nvalid [4];
            logic [7:0]  got_sum [4];
            logic        got_ovf [4];
            for (int w = 0; w < 16; w++) sw_ops[w*32 +: 32] = $urandom;
            if (t % 4 == 1) sw_ops = '1;
            sw_en = {$urandom, $urandom};
            if (t % 4 == 0 || t % 4 == 1) sw_en = '1;
            sw_sat = (t % 3 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            sw_out_ready = 1'b1;
            sw_valid = 1'b1;
            #1;
            chk($sformatf("sw%0d_in_ready", t), 64'(sw_in_ready), 64'hF);
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
            for (int d = 0; d < 4; d++) begin
                lat[d] = 0;
                nvalid[d] = 0;
                got_sum[d] = '0;
                got_ovf[d] = 1'b0;
            end
            for (int c = 1; c <= 12; c++) begin
                for (int d = 0; d < 4; d++) begin
                    if (sw_out_valid[d]) begin
                        nvalid[d]++;
                        if (lat[d] == 0) begin
                            lat[d] = c;
                            got_sum[d] = sw_out_sum[d];
                            got_ovf[d] = sw_out_ovf[d];
                        end
                    end
                end
                tick();
            end
            for (int d = 0; d < 4; d++) begin
                e = ref_sum(8, sw_n[d], sw_ops, sw_en, sw_sat);
                chk($sformatf("sw%0d_n%0d_latency", t, sw_n[d]), 64'(lat[d]), 64'(ref_lat(sw_n[d])));
                chk($sformatf("sw%0d_n%0d_count", t, sw_n[d]), 64'(nvalid[d]), 64'd1);
                chk($sformatf("sw%0d_n%0d_sum", t, sw_n[d]), 64'(got_sum[d]), 64'(e[7:0]));
                chk($sformatf("sw%0d_n%0d_ovf", t, sw_n[d]), 64'(got_ovf[d]), 64'(e[32]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
